// File: rtl/theremin_period_meter_pkg.sv
// Shared types and constants for the theremin sensor path.
package theremin_sensor_pkg;
  localparam int SAMPLE_BITS  = 8;
  localparam int SUBTICK_BITS = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } meter_state_t;

  typedef struct packed {
    logic       found;
    logic       multi;
    logic [2:0] pos;
  } edge_pos_t;
endpackage

// File: rtl/theremin_period_meter_edge_pos_encoder.sv
// Combinational oldest-edge locator over {prev, word}; bit 8 is the oldest sample.
// Position p checks sample vec[7-p] against its predecessor vec[8-p].
module edge_pos_encoder
  import theremin_sensor_pkg::*;
(
  input  logic [SAMPLE_BITS:0] vec,
  input  logic                 falling,
  output edge_pos_t            result
);
  logic [SAMPLE_BITS:0]   x;
  logic [SAMPLE_BITS-1:0] hits;

  always_comb begin
    x    = falling ? ~vec : vec;
    hits = '0;
    for (int p = 0; p < SAMPLE_BITS; p++) begin
      hits[p] = ~x[SAMPLE_BITS-p] & x[SAMPLE_BITS-1-p];
    end
  end

  always_comb begin
    result       = '0;
    result.found = |hits;
    result.multi = |(hits & (hits - 8'd1));
    // Scan newest to oldest so the oldest hit is the one left standing.
    for (int p = SAMPLE_BITS - 1; p >= 0; p--) begin
      if (hits[p]) result.pos = p[2:0];
    end
  end
endmodule

// File: rtl/theremin_period_meter.sv
// Edge timestamping period meter on 8-bit ISERDES words, 3-cycle latency.
// Optional falling-edge / HIGH_TIME logic is compiled in with THEREMIN_HIGH_TIME_EN.
module theremin_period_meter
  import theremin_sensor_pkg::*;
#(
  parameter int TS_BITS        = 24,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   CLK_PARALLEL,
  input  logic                   RESET,
  input  logic                   IN_VALID,
  input  logic [SAMPLE_BITS-1:0] IN_DATA,
  output logic [TS_BITS-1:0]     PERIOD,
  output logic                   PERIOD_VALID,
  output logic [TS_BITS-1:0]     HIGH_TIME,
  output logic                   GLITCH,
  output logic                   TIMEOUT
);
  localparam int                 CC_BITS     = TS_BITS - SUBTICK_BITS;
  localparam logic [CC_BITS-1:0] TIMEOUT_LIM = CC_BITS'(TIMEOUT_CYCLES);

  // Stage 1: capture word, boundary sample and coarse time.
  logic [CC_BITS-1:0]     cc;
  logic                   prev;
  logic                   s1_vld;
  logic [SAMPLE_BITS-1:0] s1_word;
  logic                   s1_prev;
  logic [CC_BITS-1:0]     s1_cc;

  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) begin
      cc      <= '0;
      prev    <= 1'b1;
      s1_vld  <= 1'b0;
      s1_word <= '0;
      s1_prev <= 1'b1;
      s1_cc   <= '0;
    end else begin
      cc      <= cc + CC_BITS'(1);
      if (IN_VALID) prev <= IN_DATA[0];
      s1_vld  <= IN_VALID;
      s1_word <= IN_DATA;
      s1_prev <= prev;
      s1_cc   <= cc;
    end
  end

  // Stage 2: locate edges and form timestamps.
  logic [SAMPLE_BITS:0] s1_vec;
  edge_pos_t            rise_enc;
  edge_pos_t            s2_rise;
  logic [TS_BITS-1:0]   s2_ts_rise;

  assign s1_vec = {s1_prev, s1_word};

  edge_pos_encoder u_rise (
    .vec     (s1_vec),
    .falling (1'b0),
    .result  (rise_enc)
  );

  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) begin
      s2_rise    <= '0;
      s2_ts_rise <= '0;
    end else begin
      s2_rise.found <= rise_enc.found & s1_vld;
      s2_rise.multi <= rise_enc.multi & s1_vld;
      s2_rise.pos   <= rise_enc.pos;
      s2_ts_rise    <= {s1_cc, rise_enc.pos};
    end
  end

  // Stage 3: arm/timeout FSM, subtraction and output registers.
  meter_state_t       state, state_nxt;
  logic [CC_BITS-1:0] idle_cnt;
  logic [TS_BITS-1:0] ts_last;
  logic               limit_hit;
  logic               emit_period;
  logic               emit_timeout;
  logic [TS_BITS-1:0] period_nxt;

  assign limit_hit = (idle_cnt + CC_BITS'(1)) == TIMEOUT_LIM;

  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s2_rise.found) state_nxt = ARMED;
      ARMED:   if (!s2_rise.found && limit_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An edge landing on the limit cycle takes priority over the timeout.
  always_comb begin
    emit_period  = (state == ARMED) && s2_rise.found;
    emit_timeout = (state == ARMED) && !s2_rise.found && limit_hit;
    period_nxt   = s2_ts_rise - ts_last;
  end

  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) begin
      idle_cnt     <= '0;
      ts_last      <= '0;
      PERIOD       <= '0;
      PERIOD_VALID <= 1'b0;
      GLITCH       <= 1'b0;
      TIMEOUT      <= 1'b0;
    end else begin
      if (s2_rise.found || state == IDLE || emit_timeout) idle_cnt <= '0;
      else                                                idle_cnt <= idle_cnt + CC_BITS'(1);
      if (s2_rise.found) ts_last <= s2_ts_rise;
      if (emit_period)   PERIOD  <= period_nxt;
      PERIOD_VALID <= emit_period;
      GLITCH       <= s2_rise.multi;
      TIMEOUT      <= emit_timeout;
    end
  end

`ifdef THEREMIN_HIGH_TIME_EN
  edge_pos_t          fall_enc;
  edge_pos_t          s2_fall;
  logic [TS_BITS-1:0] s2_ts_fall;
  logic               fall_seen;
  logic [TS_BITS-1:0] ts_fall;
  logic               fall_before;
  logic               fall_after;
  logic [TS_BITS-1:0] high_nxt;

  edge_pos_encoder u_fall (
    .vec     (s1_vec),
    .falling (1'b1),
    .result  (fall_enc)
  );

  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) begin
      s2_fall    <= '0;
      s2_ts_fall <= '0;
    end else begin
      s2_fall.found <= fall_enc.found & s1_vld;
      s2_fall.multi <= fall_enc.multi & s1_vld;
      s2_fall.pos   <= fall_enc.pos;
      s2_ts_fall    <= {s1_cc, fall_enc.pos};
    end
  end

  // A fall older than the rise in the same word closes the current high phase;
  // a younger one belongs to the next period.
  always_comb begin
    fall_before = s2_fall.found && (!s2_rise.found || (s2_fall.pos < s2_rise.pos));
    fall_after  = s2_fall.found && s2_rise.found && (s2_fall.pos > s2_rise.pos);
    if (fall_before)    high_nxt = s2_ts_fall - ts_last;
    else if (fall_seen) high_nxt = ts_fall - ts_last;
    else                high_nxt = period_nxt;
  end

  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) begin
      fall_seen <= 1'b0;
      ts_fall   <= '0;
      HIGH_TIME <= '0;
    end else begin
      if (s2_rise.found) begin
        fall_seen <= fall_after;
        ts_fall   <= s2_ts_fall;
      end else if (s2_fall.found) begin
        fall_seen <= 1'b1;
        ts_fall   <= s2_ts_fall;
      end
      if (emit_period) HIGH_TIME <= high_nxt;
    end
  end
`else
  assign HIGH_TIME = '0;
`endif
endmodule

// File: tb/tb_theremin_period_meter.sv
// Directed + randomized bench for theremin_period_meter against a tick-level reference model.
module tb_theremin_period_meter;
  localparam int TSB  = 8;
  localparam int TO   = 20;
  localparam int MASK = (1 << TSB) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           vld = 1'b0;
  logic [7:0]     dat = 8'h00;
  logic [TSB-1:0] period, high_time;
  logic           period_valid, glitch, timeout;

  theremin_period_meter #(.TS_BITS(TSB), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_PARALLEL (clk),
    .RESET        (rst),
    .IN_VALID     (vld),
    .IN_DATA      (dat),
    .PERIOD       (period),
    .PERIOD_VALID (period_valid),
    .HIGH_TIME    (high_time),
    .GLITCH       (glitch),
    .TIMEOUT      (timeout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int seg      = 0;

  logic [7:0] w_q[$];
  bit         v_q[$];
  int         e_pv[$], e_p[$], e_h[$], e_gl[$], e_to[$];

  task automatic check(string tag, int slot, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL seg%0d slot%0d %s: observed %0d expected %0d", seg, slot, tag, obs, exp);
    end
  endtask

  task automatic push(bit v, logic [7:0] d);
    v_q.push_back(v);
    w_q.push_back(d);
  endtask

  // Square wave sampled at tick t = 8*slot + j; sample j sits in bit 7-j.
  task automatic push_square(int ncyc, int per, int duty, int phase, int drop_pct);
    for (int k = 0; k < ncyc; k++) begin
      int n = w_q.size();
      logic [7:0] d;
      for (int j = 0; j < 8; j++) d[7-j] = (((n * 8 + j + phase) % per) < duty);
      push($urandom_range(99) >= drop_pct, d);
    end
  endtask

  // Reference: scan each valid word in time order, oldest rise/fall per word wins.
  task automatic model();
    bit prev = 1'b1, armed = 1'b0, fseen = 1'b0;
    int last_ts = 0, last_n = 0, tfall = 0, hp = 0, hh = 0;
    e_pv.delete(); e_p.delete(); e_h.delete(); e_gl.delete(); e_to.delete();
    for (int n = 0; n < w_q.size(); n++) begin
      int rp = -1, fp = -1, nr = 0, pv = 0, gl = 0, to = 0;
      if (v_q[n]) begin
        logic [8:0] s = {prev, w_q[n]};
        for (int j = 0; j < 8; j++) begin
          if (!s[8-j] && s[7-j]) begin
            nr++;
            if (rp < 0) rp = j;
          end
          if (s[8-j] && !s[7-j] && fp < 0) fp = j;
        end
        prev = w_q[n][0];
      end
      if (rp >= 0) begin
        int rts = (n * 8 + rp) & MASK;
        gl = (nr > 1);
        if (armed) begin
          pv = 1;
          hp = (rts - last_ts) & MASK;
          if (fp >= 0 && fp < rp) hh = (((n * 8 + fp) & MASK) - last_ts) & MASK;
          else if (fseen)         hh = (tfall - last_ts) & MASK;
          else                    hh = hp;
        end
        armed   = 1'b1;
        last_ts = rts;
        last_n  = n;
        fseen   = (fp > rp);
        if (fp > rp) tfall = (n * 8 + fp) & MASK;
      end else begin
        if (fp >= 0) begin
          fseen = 1'b1;
          tfall = (n * 8 + fp) & MASK;
        end
        if (armed && (n - last_n) == TO) begin
          to    = 1;
          armed = 1'b0;
        end
      end
      e_pv.push_back(pv);
      e_p.push_back(hp);
`ifdef THEREMIN_HIGH_TIME_EN
      e_h.push_back(hh);
`else
      e_h.push_back(0);
`endif
      e_gl.push_back(gl);
      e_to.push_back(to);
    end
  endtask

  task automatic check_slot(int i);
    if (i < 3) begin
      check("period_valid", i, period_valid, 0);
      check("period",       i, period,       0);
      check("high_time",    i, high_time,    0);
      check("glitch",       i, glitch,       0);
      check("timeout",      i, timeout,      0);
    end else begin
      check("period_valid", i, period_valid, e_pv[i-3]);
      check("period",       i, period,       e_p[i-3]);
      check("high_time",    i, high_time,    e_h[i-3]);
      check("glitch",       i, glitch,       e_gl[i-3]);
      check("timeout",      i, timeout,      e_to[i-3]);
    end
  endtask

  task automatic drive(int i, int n);
    if (i < n) begin
      vld = v_q[i];
      dat = w_q[i];
    end else begin
      vld = 1'b1;
      dat = 8'h3C;
    end
  endtask

  // Reset lands while edge-bearing words are still in the pipe; none may surface.
  task automatic run_segment();
    int n = w_q.size();
    model();
    @(negedge clk);
    rst = 1'b1; vld = 1'b1; dat = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_slot(0);
    drive(0, n);
    for (int i = 1; i < n + 3; i++) begin
      @(negedge clk);
      check_slot(i);
      drive(i, n);
    end
    seg++;
    w_q.delete();
    v_q.delete();
  endtask

  initial begin
    // First edge only arms, then timeout, then a re-arm without a period.
    push(1, 8'h0F);
    for (int k = 0; k < 24; k++) push(1, 8'h00);
    push(1, 8'h0F);
    for (int k = 0; k < 5; k++) push(1, 8'h00);
    run_segment();

    // Steady 37/18 square wave.
    push_square(48, 37, 18, $urandom_range(36), 0);
    run_segment();

    // Word-boundary rises at p=0.
    push(1, 8'h00); push(1, 8'hFF); push(1, 8'h00); push(1, 8'hFF);
    push(1, 8'h00); push(1, 8'h00); push(1, 8'hFF); push(1, 8'h00);
    run_segment();

    // 100-tick period across repeated coarse-counter wraps.
    push_square(60, 100, 50, $urandom_range(99), 0);
    run_segment();

    // Glitch word mid-stream.
    push_square(12, 37, 18, $urandom_range(36), 0);
    push(1, 8'h55);
    push_square(10, 37, 18, 0, 0);
    run_segment();

    // Edge on the limit cycle wins; one cycle later the timeout wins.
    push(1, 8'h01);
    for (int k = 0; k < 19; k++) push(1, 8'h00);
    push(1, 8'h01);
    for (int k = 0; k < 20; k++) push(1, 8'h00);
    push(1, 8'h01);
    for (int k = 0; k < 3; k++) push(1, 8'h00);
    run_segment();

    // Random waveforms with IN_VALID drops.
    for (int r = 0; r < 4; r++) begin
      int per  = $urandom_range(150, 12);
      int duty = $urandom_range(per - 1, 1);
      push_square(50, per, duty, $urandom_range(per - 1), 10);
      run_segment();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/theremin_period_meter.md
# theremin_period_meter

Downstream consumer of the 8-bit ISERDES sample word in the theremin sensor path. Runs in the 150 MHz parallel domain and finds rising edges at 1/1200 MHz resolution, about 0.833 ns per tick. Timestamps each edge and emits the edge-to-edge period, with a timeout when the oscillator stops. Output feeds the frequency averaging and AXI register logic.

## Interface
- `TS_BITS`, 24: timestamp and period width in ticks. The coarse counter is `TS_BITS-3` bits.
- `TIMEOUT_CYCLES`, 65535: CLK_PARALLEL cycles without a rising edge before the meter disarms. Must be < 2^(TS_BITS-3).
- `CLK_PARALLEL`  in  1  150 MHz clock, the same clock that drives the ISERDES CLKDIV.
- `RESET`  in  1  synchronous, active-high reset.
- `IN_VALID`  in  1  high when `IN_DATA` holds a valid sample word. Low during the ISERDES CE warm-up.
- `IN_DATA`  in  8  sample word. Bit 7 is the oldest sample, bit 0 the newest.
- `PERIOD`  out  TS_BITS  ticks between the last two rising edges.
- `PERIOD_VALID`  out  1  one-cycle strobe qualifying `PERIOD` and `HIGH_TIME`.
- `HIGH_TIME`  out  TS_BITS  ticks from the previous rising edge to the falling edge that followed it.
- `GLITCH`  out  1  one-cycle strobe: a word contained more than one rising edge.
- `TIMEOUT`  out  1  one-cycle strobe: no rising edge for `TIMEOUT_CYCLES` cycles.

## Operation
- Coarse counter `cc` increments every cycle, including cycles with `IN_VALID`=0. It wraps modulo 2^(TS_BITS-3).
- Edge search vector, oldest first: `{prev, IN_DATA[7:0]}`, 9 bits.
  - `prev` is bit 0 of the last valid word. Reset value 1, so the first valid word cannot report a spurious boundary edge.
  - `prev` updates only when `IN_VALID`=1.
- Rising edge at position p (0..7, where 0 means `IN_DATA[7]`) when the sample before it is 0 and the sample at p is 1.
  - If several rising edges occur in one word, the lowest p (oldest) is used and `GLITCH` pulses.
  - Falling edges are located the same way. Lowest p wins; a second falling edge in the same word does not pulse `GLITCH`.
- Timestamp of an edge: `{cc_at_sample, p[2:0]}`, TS_BITS wide.
- Period: `ts_now - ts_last`, modulo 2^TS_BITS. Wrap-around of `cc` between the two edges is therefore transparent.
- State machine, with states `IDLE` and `ARMED`:
  - `IDLE` → `ARMED` on the first rising edge. That edge stores `ts_last`; no `PERIOD_VALID`.
  - In `ARMED`, each rising edge emits `PERIOD`, strobes `PERIOD_VALID`, and updates `ts_last`.
  - `ARMED` → `IDLE` when the idle counter reaches `TIMEOUT_CYCLES`. `TIMEOUT` pulses once. The idle counter counts cycles since the last rising edge and clears on each one.
  - If a rising edge arrives in the same cycle the limit is reached, the edge wins: no `TIMEOUT`, the period is reported.
- Words with `IN_VALID`=0 are not searched and produce no edges.
- `RESET` mid-operation discards any in-flight pipeline contents. No strobe is emitted for data accepted before reset.

## Timing
- 3-stage pipeline:
  - Stage 1 registers the word, `prev` and `cc`.
  - Stage 2 runs the priority encode and builds the timestamp.
  - Stage 3 subtracts and drives the outputs.
- A word accepted on edge k produces `PERIOD_VALID` / `GLITCH` high during the cycle after edge k+2 (latency 3).
- `TIMEOUT` has the same 3-cycle alignment relative to the word that hits the limit.
- Reset values:
  - `PERIOD`=0, `HIGH_TIME`=0, `PERIOD_VALID`=0, `GLITCH`=0, `TIMEOUT`=0.
  - State `IDLE`, `cc`=0, idle counter 0, `prev`=1.
- Outputs are registered and hold their value between strobes.
- Throughput: one period per cycle maximum.

## Configuration
- `THEREMIN_HIGH_TIME_EN` defined:
  - Falling-edge search and a `ts_fall` register are compiled in.
  - `HIGH_TIME` = `ts_fall - ts_last`, computed at the next rising edge and qualified by `PERIOD_VALID`.
  - If no falling edge was seen since the last rising edge, `HIGH_TIME` = `PERIOD`.
- Not defined: `HIGH_TIME` is constant 0 and no falling-edge logic is synthesised. All other behaviour is identical.

## Structure
- Package `theremin_sensor_pkg`:
  - `SAMPLE_BITS`=8.
  - `SUBTICK_BITS`=3.
  - `meter_state_t` enum {`IDLE`, `ARMED`}.
  - `edge_pos_t` struct: `found`, `multi`, `pos[2:0]`.
- Sub-module `edge_pos_encoder`: combinational. Input is the 9-bit vector plus a polarity select; output is `edge_pos_t`. One instance serves rising edges, a second serves falling edges under the macro.

## Test plan
- Reset and first edge: assert `RESET`, release, feed one word 8'h0F. All outputs 0, no `PERIOD_VALID` (first edge only arms).
- Steady square wave, period 37 ticks and duty 18: `PERIOD_VALID` every period, `PERIOD`=37. With the macro, `HIGH_TIME`=18.
- Word-boundary edge: previous word 8'h00 then 8'hFF, so p=0. Timestamp low bits 0 and the next `PERIOD` is exact.
- Counter wrap: `TS_BITS`=8, period 100 ticks across a `cc` wrap → `PERIOD`=100.
- Glitch: feed 8'h55 while `ARMED` → `GLITCH`=1 for one cycle. The period uses p=1.
- Timeout: stop edges, `TIMEOUT_CYCLES`=20 → `TIMEOUT` strobes once, about 20 cycles after the last edge. The next edge only re-arms (no `PERIOD_VALID`).
